// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MIPS data-memory initiator: size encodings,
// FSM state enum and the big-endian byte-enable mapping.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    ACCESS    = 3'd2,
    ACCESS_HI = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Reserved size code 3 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SZ_WORD : size;
  endfunction

  // Lanes covered by an access that starts at offset 0 (bit3 = offset 0).
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'b1000;
      SZ_HALF: return 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  // Byte enable for {size, addr[1:0]}; lanes past offset 3 fall off the word.
  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
    return size_mask(size) >> off;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the initiator (master) and DataMemory (slave).
// Handshake: while mem_rd or mem_wr is high the master holds mem_addr,
// mem_be and mem_wdata stable; the cycle in which mem_ready is sampled high
// completes that strobe (and mem_rdata is valid for reads in that cycle).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_be, mem_rd, mem_wr,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_be, mem_rd, mem_wr,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: picks the addressed bytes out of a two-word big-endian
// window and sign- or zero-extends them to 32 bits.
import mips_mem_pkg::*;

module mem_load_align (
  input  logic [63:0] win,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data
);
  logic [63:0] shifted;
  logic [31:0] top;

  // Shift the first addressed byte up to bit 63, then extend by size.
  always_comb begin
    shifted = win << {off, 3'b000};
    top     = shifted[63:32];
    case (size)
      SZ_BYTE: data = {{24{sign_ext & top[31]}}, top[31:24]};
      SZ_HALF: data = {{16{sign_ext & top[31]}}, top[31:16]};
      default: data = top;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the big-endian data-memory interface for the MIPS
// execute/memory stage. Optional build macro MISALIGN_SPLIT_EN turns
// word-crossing misaligned accesses into two bus phases instead of addr_err.
import mips_mem_pkg::*;

module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              MemoryRead,
  input  logic              MemoryWrite,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [31:0]       store_data,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              addr_err,
  output logic              bus_err,
  output state_t            state_dbg,
  mem_access_unit_if.master bus
);
  state_t            state_q, state_d;
  logic              is_write_q, sign_q, aerr_q, berr_q;
  logic [1:0]        sz_q, off_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       sd_q, rdata_lo_q, rdata_hi_q, aligned;
  logic [7:0]        cnt_q;
  logic              accept, in_acc, timeout_hit, chk_err, need_split;
  logic [7:0]        mask8;
  logic [31:0]       just;
  logic [63:0]       wide;

  assign accept      = req_valid & (MemoryRead | MemoryWrite);
  assign in_acc      = (state_q == ACCESS) || (state_q == ACCESS_HI);
  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

`ifdef MISALIGN_SPLIT_EN
  // Only accesses that run past byte 3 need a second word.
  assign chk_err    = 1'b0;
  assign need_split = ((sz_q == SZ_HALF) && (off_q == 2'd3)) ||
                      ((sz_q == SZ_WORD) && (off_q != 2'd0));
`else
  assign chk_err    = ((sz_q == SZ_HALF) && off_q[0]) ||
                      ((sz_q == SZ_WORD) && (off_q != 2'd0));
  assign need_split = 1'b0;
`endif

  // Lane placement of enables and store data across the two-word window.
  always_comb begin
    mask8 = {size_mask(sz_q), 4'b0000} >> off_q;
    case (sz_q)
      SZ_BYTE: just = {sd_q[7:0], 24'h0};
      SZ_HALF: just = {sd_q[15:0], 16'h0};
      default: just = sd_q;
    endcase
    wide = {just, 32'h0} >> {off_q, 3'b000};
  end

  // Next-state logic; the state register follows below.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = CHECK;
      CHECK:     state_d = chk_err ? DONE : ACCESS;
      ACCESS: begin
        if (bus.mem_ready)    state_d = need_split ? ACCESS_HI : DONE;
        else if (timeout_hit) state_d = DONE;
      end
      ACCESS_HI: if (bus.mem_ready || timeout_hit) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch, error flags, read capture and per-phase timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_write_q <= 1'b0;
      sign_q     <= 1'b0;
      sz_q       <= SZ_BYTE;
      off_q      <= 2'd0;
      waddr_q    <= '0;
      sd_q       <= '0;
      aerr_q     <= 1'b0;
      berr_q     <= 1'b0;
      rdata_lo_q <= '0;
      rdata_hi_q <= '0;
      cnt_q      <= '0;
    end else begin
      if (state_q == IDLE && accept) begin
        is_write_q <= MemoryWrite;
        sign_q     <= sign_ext;
        sz_q       <= norm_size(size);
        off_q      <= ALUResult[1:0];
        waddr_q    <= {ALUResult[ADDR_W-1:2], 2'b00};
        sd_q       <= store_data;
        aerr_q     <= 1'b0;
        berr_q     <= 1'b0;
        rdata_lo_q <= '0;
        rdata_hi_q <= '0;
      end
      if (state_q == CHECK) aerr_q <= chk_err;
      if (state_q == ACCESS && bus.mem_ready) rdata_lo_q <= bus.mem_rdata;
      if (state_q == ACCESS_HI && bus.mem_ready) rdata_hi_q <= bus.mem_rdata;
      if (in_acc && !bus.mem_ready && timeout_hit) berr_q <= 1'b1;
      cnt_q <= (in_acc && state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
    end
  end

  mem_load_align u_align (
    .win      ({rdata_lo_q, rdata_hi_q}),
    .off      (off_q),
    .size     (sz_q),
    .sign_ext (sign_q),
    .data     (aligned)
  );

  assign bus.mem_rd    = in_acc & ~is_write_q;
  assign bus.mem_wr    = in_acc & is_write_q;
  assign bus.mem_addr  = (state_q == ACCESS)    ? waddr_q :
                         (state_q == ACCESS_HI) ? waddr_q + ADDR_W'(4) : '0;
  assign bus.mem_be    = (state_q == ACCESS)    ? mask8[7:4] :
                         (state_q == ACCESS_HI) ? mask8[3:0] : 4'b0000;
  assign bus.mem_wdata = !is_write_q             ? 32'h0 :
                         (state_q == ACCESS)    ? wide[63:32] :
                         (state_q == ACCESS_HI) ? wide[31:0] : 32'h0;

  assign done      = (state_q == DONE);
  assign addr_err  = done & aerr_q;
  assign bus_err   = done & berr_q;
  assign load_data = (done && !is_write_q && !aerr_q && !berr_q) ? aligned : 32'h0;
  assign stall     = req_valid & ~done;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus hand-written
// sequences for misalignment, timeout and mid-access reset.
import mips_mem_pkg::*;

module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, MemoryRead = 1'b0, MemoryWrite = 1'b0;
  logic [31:0] ALUResult = '0, store_data = '0;
  logic [1:0]  size = 2'd0;
  logic        sign_ext = 1'b0;
  logic        stall, done, addr_err, bus_err;
  logic [31:0] load_data;
  state_t      state_dbg;

  logic        ready_v = 1'b1, use_map = 1'b0;
  logic [31:0] rdata_v = '0;

  int n_vec = 0;
  int n_bad = 0;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  assign bus.mem_ready = ready_v;
  assign bus.mem_rdata = !use_map ? rdata_v :
                         (bus.mem_addr == 32'h0) ? 32'h11223344 : 32'h55667788;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .MemoryRead(MemoryRead),
    .MemoryWrite(MemoryWrite), .ALUResult(ALUResult), .store_data(store_data),
    .size(size), .sign_ext(sign_ext), .stall(stall), .done(done),
    .load_data(load_data), .addr_err(addr_err), .bus_err(bus_err),
    .state_dbg(state_dbg), .bus(bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, sd;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_wr;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[12];

  // Observations of the last access
  logic        o_done, o_rd, o_wr, o_both, o_aerr, o_berr, o_stall1, o_stall_done;
  int          o_lat, o_str;
  logic [31:0] o_addr, o_addr2, o_wdata, o_load;
  logic [3:0]  o_be, o_be2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Driver: present one request, watch the bus until done or 40 cycles.
  task automatic run(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] sd, input logic [1:0] sz, input logic sgn);
    @(negedge clk);
    MemoryRead = rd; MemoryWrite = wr; ALUResult = addr; store_data = sd;
    size = sz; sign_ext = sgn; req_valid = 1'b1;
    o_done = 0; o_rd = 0; o_wr = 0; o_both = 0; o_aerr = 0; o_berr = 0;
    o_stall1 = 0; o_stall_done = 1; o_lat = 0; o_str = 0;
    o_addr = '0; o_addr2 = '0; o_wdata = '0; o_load = '0; o_be = '0; o_be2 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) begin
        o_stall1 = stall;
        ALUResult = 32'hBAD0_0003;
        store_data = 32'h5555_5555;
      end
      if (bus.mem_rd || bus.mem_wr) begin
        if (bus.mem_rd && bus.mem_wr) o_both = 1;
        if (o_str == 0) begin
          o_addr = bus.mem_addr; o_be = bus.mem_be; o_wdata = bus.mem_wdata;
          o_rd = bus.mem_rd; o_wr = bus.mem_wr;
        end else if (o_str == 1) begin
          o_addr2 = bus.mem_addr; o_be2 = bus.mem_be;
        end
        o_str++;
      end
      if (done) begin
        o_done = 1; o_lat = c; o_load = load_data; o_aerr = addr_err;
        o_berr = bus_err; o_stall_done = stall;
        break;
      end
    end
    req_valid = 1'b0; MemoryRead = 1'b0; MemoryWrite = 1'b0;
    if (!o_done) chk("done_bound", 32'd0, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h10, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 32'h10, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 32'h13, 32'h0,        2'd0, 1'b1, 32'h000000F0, 32'h10, 4'b0001, 32'h0,        1'b0, 32'hFFFFFFF0};
    vecs[2]  = '{1'b1, 1'b0, 32'h13, 32'h0,        2'd0, 1'b0, 32'h000000F0, 32'h10, 4'b0001, 32'h0,        1'b0, 32'h000000F0};
    vecs[3]  = '{1'b0, 1'b1, 32'h22, 32'h0000ABCD, 2'd1, 1'b0, 32'h0,        32'h20, 4'b0011, 32'h0000ABCD, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 32'h31, 32'h12345677, 2'd0, 1'b0, 32'h0,        32'h30, 4'b0100, 32'h00770000, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h40, 32'h0,        2'd1, 1'b1, 32'h80011234, 32'h40, 4'b1100, 32'h0,        1'b0, 32'hFFFF8001};
    vecs[6]  = '{1'b1, 1'b0, 32'h42, 32'h0,        2'd1, 1'b0, 32'h80011234, 32'h40, 4'b0011, 32'h0,        1'b0, 32'h00001234};
    vecs[7]  = '{1'b0, 1'b1, 32'h50, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0,        32'h50, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h60, 32'h0,        2'd3, 1'b0, 32'h01020304, 32'h60, 4'b1111, 32'h0,        1'b0, 32'h01020304};
    vecs[9]  = '{1'b1, 1'b1, 32'h70, 32'hA5A5A5A5, 2'd2, 1'b0, 32'h0,        32'h70, 4'b1111, 32'hA5A5A5A5, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h11, 32'h0,        2'd0, 1'b1, 32'h007F0000, 32'h10, 4'b0100, 32'h0,        1'b0, 32'h0000007F};
    vecs[11] = '{1'b1, 1'b0, 32'h46, 32'h0,        2'd1, 1'b1, 32'h1234ABCD, 32'h44, 4'b0011, 32'h0,        1'b0, 32'hFFFFABCD};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_be", 32'(bus.mem_be), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_load", load_data, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // Table vectors, memory ready on the first ACCESS cycle
    for (int i = 0; i < 12; i++) begin
      rdata_v = vecs[i].rdata;
      run(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].sd, vecs[i].sz, vecs[i].sgn);
      chk($sformatf("v%0d_lat", i), 32'(o_lat), 32'd3);
      chk($sformatf("v%0d_strobes", i), 32'(o_str), 32'd1);
      chk($sformatf("v%0d_addr", i), o_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_be", i), 32'(o_be), 32'(vecs[i].e_be));
      chk($sformatf("v%0d_wdata", i), o_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_wr", i), 32'(o_wr), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_rd", i), 32'(o_rd), 32'(!vecs[i].e_wr));
      chk($sformatf("v%0d_both", i), 32'(o_both), 32'd0);
      chk($sformatf("v%0d_load", i), o_load, vecs[i].e_load);
      chk($sformatf("v%0d_aerr", i), 32'(o_aerr), 32'd0);
      chk($sformatf("v%0d_berr", i), 32'(o_berr), 32'd0);
      chk($sformatf("v%0d_stall1", i), 32'(o_stall1), 32'd1);
      chk($sformatf("v%0d_stall_done", i), 32'(o_stall_done), 32'd0);
    end

    // Misaligned word load at 0x01
    use_map = 1'b1;
    run(1'b1, 1'b0, 32'h01, 32'h0, 2'd2, 1'b0);
`ifdef MISALIGN_SPLIT_EN
    chk("mis_lat", 32'(o_lat), 32'd4);
    chk("mis_strobes", 32'(o_str), 32'd2);
    chk("mis_addr0", o_addr, 32'h0);
    chk("mis_be0", 32'(o_be), 32'(4'b0111));
    chk("mis_addr1", o_addr2, 32'h4);
    chk("mis_be1", 32'(o_be2), 32'(4'b1000));
    chk("mis_load", o_load, 32'h22334455);
    chk("mis_aerr", 32'(o_aerr), 32'd0);
`else
    chk("mis_lat", 32'(o_lat), 32'd2);
    chk("mis_strobes", 32'(o_str), 32'd0);
    chk("mis_aerr", 32'(o_aerr), 32'd1);
    chk("mis_load", o_load, 32'h0);
`endif
    use_map = 1'b0;

    // Timeout: memory never ready
    ready_v = 1'b0;
    rdata_v = 32'hFFFFFFFF;
    run(1'b1, 1'b0, 32'h80, 32'h0, 2'd2, 1'b0);
    chk("to_strobes", 32'(o_str), 32'd16);
    chk("to_lat", 32'(o_lat), 32'd18);
    chk("to_berr", 32'(o_berr), 32'd1);
    chk("to_aerr", 32'(o_aerr), 32'd0);
    chk("to_load", o_load, 32'h0);
    chk("to_stall_done", 32'(o_stall_done), 32'd0);
    @(negedge clk);
    chk("to_rd_after", 32'(bus.mem_rd), 32'd0);
    chk("to_stall_after", 32'(stall), 32'd0);

    // Reset in the middle of an ACCESS
    MemoryRead = 1'b1; ALUResult = 32'h90; size = 2'd2; req_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("ra_in_access", 32'(bus.mem_rd), 32'd1);
    rst = 1'b1; req_valid = 1'b0; MemoryRead = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("ra_state", 32'(state_dbg), 32'(IDLE));
    chk("ra_rd", 32'(bus.mem_rd), 32'd0);
    chk("ra_addr", bus.mem_addr, 32'd0);
    chk("ra_be", 32'(bus.mem_be), 32'd0);
    chk("ra_done", 32'(done), 32'd0);
    chk("ra_stall", 32'(stall), 32'd0);
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      chk("ra_no_done", 32'(seen), 32'd0);
    end
    ready_v = 1'b1;
    rdata_v = 32'hDEADBEEF;
    run(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    chk("ra_after_lat", 32'(o_lat), 32'd3);
    chk("ra_after_load", o_load, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface. Takes load/store requests from the MIPS execute/memory stage and drives the byte-addressed, big-endian data memory.
- Generates byte enables and aligned write data, then waits for the memory's ready handshake. Returns sign- or zero-extended load data and stalls the pipeline while an access is outstanding.
- Sits between the ALU result/register-file read path and the DataMemory responder.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 16, max cycles waiting for mem_ready before bus_err; range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  pipeline presents an access; held until done
- MemoryRead  in  1  load request
- MemoryWrite  in  1  store request
- ALUResult  in  ADDR_W  byte address
- store_data  in  32  register data for stores (right-justified for sb/sh)
- size  in  2  0=byte, 1=half, 2=word; 3 is reserved, treated as word
- sign_ext  in  1  1 = lb/lh, 0 = lbu/lhu
- stall  out  1  hold pipeline
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result, valid with done
- addr_err  out  1  misalignment, pulses with done
- bus_err  out  1  timeout, pulses with done
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits forced 0
- mem_wdata  out  32  lane-positioned store data
- mem_be  out  4  byte enables; bit3 = bits 31:24 = address offset 0
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_rdata  in  32  memory read word
- mem_ready  in  1  memory completes current strobe

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. rst mid-access aborts immediately; no done pulse.
- Big-endian lanes: offset k occupies bits [31-8k:24-8k].
- IDLE: when req_valid is high and exactly one of MemoryRead/MemoryWrite is high, latch address, size, sign_ext and store_data, then go to CHECK.
  - Both MemoryRead and MemoryWrite high: write wins, and stores are performed read-modify-free via mem_be.
  - Neither high: ignored.
- CHECK (1 cycle):
  - Misaligned if half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned: go to DONE with addr_err=1; no memory strobe.
  - Otherwise compute mem_be and mem_wdata, and go to ACCESS.
- ACCESS: assert mem_rd or mem_wr, plus mem_addr and mem_be, every cycle until mem_ready is sampled high.
  - On mem_ready: capture mem_rdata, go to DONE.
  - Counter increments each ACCESS cycle. If it reaches TIMEOUT without mem_ready: deassert strobes, go to DONE with bus_err=1, load_data=0.
- DONE (1 cycle): done=1, load_data valid, then return to IDLE.
- Load extension: selected lane shifted to bits [7:0] or [15:0], then sign- or zero-extended; word returned unchanged.
- stall = req_valid & ~done, combinational. Minimum latency with mem_ready high on the first ACCESS cycle is 3 cycles (accept, CHECK, ACCESS → DONE).
- Strobes are never asserted outside ACCESS, and mem_rd and mem_wr are never asserted together.
- Inputs changing while busy are ignored, because latched values are used.

Optional Feature:
- Macro: MISALIGN_SPLIT_EN.
- Defined: misaligned half/word accesses are not errors. They are split into two ACCESS phases (ACCESS_LO then ACCESS_HI, next word address, wrapping at 2^ADDR_W).
  - Loads assemble the bytes big-endian; stores use partial mem_be on each word.
  - The timeout restarts per phase.
  - A bus_err in phase 1 skips phase 2.
  - addr_err stays 0.
- Undefined: behaviour as above; addr_err reported, and no memory access occurs.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state enum (IDLE, CHECK, ACCESS, ACCESS_HI, DONE);
  - the function mapping {size, addr[1:0]} to the 4-bit big-endian byte enable.
- One natural sub-module: mem_load_align, combinational lane select plus extension.

Test Plan:
- lw: addr 0x10, mem_rdata 0xDEADBEEF, mem_ready on 1st ACCESS cycle → mem_be=1111, done at cycle 3, load_data=0xDEADBEEF.
- lb vs lbu: addr 0x13 (offset 3), mem_rdata 0x000000F0. sign_ext=1 → 0xFFFFFFF0; sign_ext=0 → 0x000000F0.
- sh: addr 0x22, store_data 0x0000ABCD → mem_addr=0x20, mem_be=0011, mem_wdata[15:0]=0xABCD, mem_wr held 1 cycle.
- lw at addr 0x01, macro off → addr_err=1 with done, mem_rd never asserted. Macro on: two reads at 0x00/0x04, bytes 1..3 of word0 followed by byte 0 of word1.
- mem_ready held 0, TIMEOUT=16 → bus_err with done after 16 ACCESS cycles, strobes drop, stall released.
- rst asserted during ACCESS → next cycle all outputs 0, state IDLE, no done; new request afterwards completes normally.
